// File: rtl/uart_tx_arbiter.sv
// Purpose: two-requester arbiter that feeds single bytes to a UART transmitter.
// Latency: a request seen while idle with the transmitter free is written out (tx_wr/gnt) one cycle later.
// Backpressure: requests are held until granted; no grant while en=0, tx_busy=1 or a transfer is in flight.
//
// Ports:
//   clk, reset        - system clock (rising edge) and asynchronous active-high reset
//   en                - arbiter enable, passed straight through to tx_en
//   req0/req1         - byte-send requests, held until the matching gnt pulse
//   data0/data1       - request bytes, stable while the request is held
//   gnt0/gnt1         - one-cycle accept pulses, coincident with tx_wr
//   tx_busy           - transmitter status input
//   tx_en/tx_wr       - transmitter enable and one-cycle write strobe
//   tx_data           - registered byte presented to the transmitter
//   arb_busy          - high whenever a transfer is being issued or tracked
//   last_src          - index of the most recently granted requester
//   err               - one-cycle pulse on start timeout or enable-drop abort
//
// Build option: define UART_ARB_RR_EN for round-robin between simultaneous
// requests; without it port 0 always wins a tie.

module uart_tx_arbiter #(
   parameter int START_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic       tx_busy,
   output logic       tx_en,
   output logic       tx_wr,
   output logic [7:0] tx_data,
   output logic       arb_busy,
   output logic       last_src,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISSUE      = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } state_t;

   // The start-wait counter is 4 bits wide, so START_TIMEOUT is meaningful up to 15.
   localparam logic [3:0] TIMEOUT_VAL = 4'(START_TIMEOUT);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic [3:0] cnt_inc;
   logic       err_nxt;
   logic       take;
   logic       win;

   // Winner among the current requests; only used when at least one is high.
`ifdef UART_ARB_RR_EN
   // A tie goes to the port that did not win last; last_src resets to 1 so port 0 goes first.
   assign win = (req0 & req1) ? ~last_src : req1;
`else
   // Port 0 wins whenever it is requesting.
   assign win = ~req0;
`endif

   assign cnt_inc = cnt + 4'd1;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_nxt   = 1'b0;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (en && !tx_busy && (req0 || req1)) begin
               state_nxt = ISSUE;
               take      = 1'b1;
            end
         end
         ISSUE: begin
            if (!en) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else begin
               state_nxt = WAIT_START;
               cnt_nxt   = 4'd0;
            end
         end
         WAIT_START: begin
            // tx_busy rising wins over a timeout landing on the same cycle.
            if (!en) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == TIMEOUT_VAL) begin
                  state_nxt = IDLE;
                  err_nxt   = 1'b1;
               end
            end
         end
         WAIT_DONE: begin
            // Exit goes through IDLE, so a new grant can never coincide with this exit.
            if (!en) begin
               state_nxt = IDLE;
               err_nxt   = 1'b1;
            end else if (!tx_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         err      <= 1'b0;
         tx_data  <= 8'h00;
         last_src <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
         if (take) begin
            tx_data  <= win ? data1 : data0;
            last_src <= win;
         end
      end
   end

   // Strobe and grants decode from the ISSUE state; last_src already names the
   // winner there, and an enable drop during ISSUE does not retract them.
   assign tx_en    = en;
   assign tx_wr    = (state == ISSUE);
   assign gnt0     = tx_wr & ~last_src;
   assign gnt1     = tx_wr &  last_src;
   assign arb_busy = (state != IDLE);

endmodule
